// File: rtl/carus_mem_arb_pkg.sv
// rtl/carus_mem_arb_pkg.sv - shared types and constants for the Carus bank front-end arbiter
package carus_mem_arb_pkg;

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        RET    = 2'd2,
        WAKE   = 2'd3
    } state_e;

    typedef logic port_id_t;

endpackage

// File: rtl/carus_rr_arb2.sv
// rtl/carus_rr_arb2.sv - two-input round-robin arbiter favouring the port that did not win last
module carus_rr_arb2
    import carus_mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 en,
    input  port_id_t             last_q,
    output logic [NUM_PORTS-1:0] gnt,
    output port_id_t             id
);

    always_comb begin
        id  = 1'b0;
        gnt = '0;
        if (req == 2'b11) begin
            id = ~last_q;
        end else if (req[1]) begin
            id = 1'b1;
        end
        if (en && (|req)) begin
            gnt[id] = 1'b1;
        end
    end

endmodule

// File: rtl/carus_mem_arbiter.sv
// rtl/carus_mem_arbiter.sv - two-port round-robin front-end for one Carus SRAM bank with retention sequencing
module carus_mem_arbiter
    import carus_mem_arb_pkg::*;
#(
    parameter  int NUM_WORDS   = 1024,
    parameter  int WAKE_CYCLES = 4,
    localparam int AddrWidth   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m0_req_i,
    output logic                 m0_gnt_o,
    input  logic                 m0_we_i,
    input  logic [AddrWidth-1:0] m0_addr_i,
    input  logic [31:0]          m0_wdata_i,
    input  logic [3:0]           m0_be_i,
    output logic                 m0_rvalid_o,
    output logic [31:0]          m0_rdata_o,
    input  logic                 m1_req_i,
    output logic                 m1_gnt_o,
    input  logic                 m1_we_i,
    input  logic [AddrWidth-1:0] m1_addr_i,
    input  logic [31:0]          m1_wdata_i,
    input  logic [3:0]           m1_be_i,
    output logic                 m1_rvalid_o,
    output logic [31:0]          m1_rdata_o,
    output logic                 sram_req_o,
    output logic                 sram_we_o,
    output logic [AddrWidth-1:0] sram_addr_o,
    output logic [31:0]          sram_wdata_o,
    output logic [3:0]           sram_be_o,
    input  logic [31:0]          sram_rdata_i,
    output logic                 set_retentive_no,
    input  logic                 ret_req_i,
    output logic                 ret_ack_o
);

    localparam int CntWidth = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [CntWidth-1:0] WakeLoad = CntWidth'(WAKE_CYCLES - 1);

    state_e                state_q, state_nxt;
    logic [CntWidth-1:0]   wake_q, wake_nxt;
    logic                  pending_q;
    logic                  read_q;
    port_id_t              owner_q;
    port_id_t              last_q;

    logic                  grant_en;
    logic [NUM_PORTS-1:0]  gnt;
    port_id_t              id;
    logic                  granted;
    logic                  rvalid;
    logic [31:0]           resp_data;

    carus_rr_arb2 u_rr_arb (
        .req    ({m1_req_i, m0_req_i}),
        .en     (grant_en),
        .last_q (last_q),
        .gnt    (gnt),
        .id     (id)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ACTIVE;
            wake_q    <= '0;
            pending_q <= 1'b0;
            read_q    <= 1'b0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            wake_q    <= wake_nxt;
            pending_q <= granted;
            if (granted) begin
                owner_q <= id;
                last_q  <= id;
                read_q  <= ~sram_we_o;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        wake_nxt  = wake_q;
        unique case (state_q)
            ACTIVE: if (ret_req_i) state_nxt = DRAIN;
            // Releasing the retention request aborts the drain before the bank is ever put to sleep.
            DRAIN: begin
                if (!ret_req_i)      state_nxt = ACTIVE;
                else if (!pending_q) state_nxt = RET;
            end
            RET: begin
                if (!ret_req_i) begin
                    state_nxt = WAKE;
                    wake_nxt  = WakeLoad;
                end
            end
            WAKE: begin
                if (wake_q == '0) state_nxt = ACTIVE;
                else              wake_nxt  = wake_q - 1'b1;
            end
            default: state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        grant_en         = (state_q == ACTIVE) && !ret_req_i && !rst_i;
        set_retentive_no = rst_i || (state_q != RET);
        ret_ack_o        = !rst_i && (state_q == RET);
    end

    assign granted  = |gnt;
    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    always_comb begin
        sram_req_o   = granted;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        if (granted) begin
            sram_we_o    = id ? m1_we_i    : m0_we_i;
            sram_addr_o  = id ? m1_addr_i  : m0_addr_i;
            sram_wdata_o = id ? m1_wdata_i : m0_wdata_i;
            sram_be_o    = id ? m1_be_i    : m0_be_i;
        end
    end

    // Write acknowledgements return zero data so a stale bank output never leaks upstream.
    assign rvalid      = pending_q && !rst_i;
    assign resp_data   = read_q ? sram_rdata_i : 32'h0;
    assign m0_rvalid_o = rvalid && (owner_q == 1'b0);
    assign m1_rvalid_o = rvalid && (owner_q == 1'b1);
    assign m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
    assign m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;

endmodule

// File: tb/tb_carus_mem_arbiter.sv
// tb/tb_carus_mem_arbiter.sv - directed scoreboard bench for carus_mem_arbiter
module tb_carus_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
    logic [9:0]  m0_addr_i;
    logic [31:0] m0_wdata_i, m0_rdata_o;
    logic [3:0]  m0_be_i;
    logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
    logic [9:0]  m1_addr_i;
    logic [31:0] m1_wdata_i, m1_rdata_o;
    logic [3:0]  m1_be_i;
    logic        sram_req_o, sram_we_o;
    logic [9:0]  sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [3:0]  sram_be_o;
    logic [31:0] sram_rdata_i = 32'h0;
    logic        set_retentive_no, ret_req_i, ret_ack_o;

    typedef struct {
        int          due;
        bit          port;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always #5 clk_i = ~clk_i;

    carus_mem_arbiter #(.NUM_WORDS(1024), .WAKE_CYCLES(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_be_i(m0_be_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_be_i(m1_be_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_rdata_i(sram_rdata_i),
        .set_retentive_no(set_retentive_no), .ret_req_i(ret_req_i), .ret_ack_o(ret_ack_o)
    );

    function automatic logic [31:0] bank_word(input logic [9:0] a);
        return (a == 10'd5) ? 32'hDEADBEEF : (32'hC0DE_0000 | {22'd0, a});
    endfunction

    // Bank model: one-cycle read latency.
    always @(posedge clk_i)
        sram_rdata_i <= (sram_req_o && !sram_we_o) ? bank_word(sram_addr_o) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input bit eg0, input bit eg1, input bit esr, input bit eack);
        resp_t       e;
        logic        ev0, ev1, ewe;
        logic [31:0] ed0, ed1, ewd;
        logic [9:0]  ea;
        logic [3:0]  ebe;
        @(negedge clk_i);
        if (rst_i) sb.delete();
        ev0 = 1'b0; ev1 = 1'b0; ed0 = 32'h0; ed1 = 32'h0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.port) begin ev1 = 1'b1; ed1 = e.data; end
            else        begin ev0 = 1'b1; ed0 = e.data; end
        end
        chk("m0_gnt", m0_gnt_o, eg0);
        chk("m1_gnt", m1_gnt_o, eg1);
        chk("sram_req", sram_req_o, eg0 | eg1);
        chk("set_retentive_no", set_retentive_no, esr);
        chk("ret_ack", ret_ack_o, eack);
        chk("m0_rvalid", m0_rvalid_o, ev0);
        chk("m1_rvalid", m1_rvalid_o, ev1);
        chk("m0_rdata", m0_rdata_o, ed0);
        chk("m1_rdata", m1_rdata_o, ed1);
        if (eg0 | eg1) begin
            ewe = eg1 ? m1_we_i : m0_we_i;
            ea  = eg1 ? m1_addr_i : m0_addr_i;
            ewd = eg1 ? m1_wdata_i : m0_wdata_i;
            ebe = eg1 ? m1_be_i : m0_be_i;
            sb.push_back('{due: cyc + 1, port: eg1, data: ewe ? 32'h0 : bank_word(ea)});
        end else begin
            ewe = 1'b0; ea = 10'd0; ewd = 32'h0; ebe = 4'h0;
        end
        chk("sram_we", sram_we_o, ewe);
        chk("sram_addr", sram_addr_o, ea);
        chk("sram_wdata", sram_wdata_o, ewd);
        chk("sram_be", sram_be_o, ebe);
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    initial begin
        rst_i = 1'b1; ret_req_i = 1'b0;
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 10'd1; m0_wdata_i = 32'h0; m0_be_i = 4'hF;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 10'd2; m1_wdata_i = 32'h0; m1_be_i = 4'hF;
        @(posedge clk_i); #1;
        cycle(0, 0, 1, 0);
        rst_i = 1'b0;

        // Single m0 read of address 5.
        m1_req_i = 1'b0; m0_addr_i = 10'd5;
        cycle(1, 0, 1, 0);
        m0_req_i = 1'b0;
        cycle(0, 0, 1, 0);

        // m1 partial write to the top word.
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 10'h3FF; m1_wdata_i = 32'h12345678; m1_be_i = 4'b0011;
        cycle(0, 1, 1, 0);
        m1_req_i = 1'b0;
        cycle(0, 0, 1, 0);

        // Continuous contention alternates starting with m0.
        m0_req_i = 1'b1; m1_req_i = 1'b1; m1_we_i = 1'b0; m1_be_i = 4'hF; m0_be_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            m0_addr_i = 10'(i);
            m1_addr_i = 10'(10'h100 + i);
            cycle((i % 2) == 0, (i % 2) == 1, 1, 0);
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        cycle(0, 0, 1, 0);

        // Retention request right after a read grant.
        m0_req_i = 1'b1; m0_addr_i = 10'd7;
        cycle(1, 0, 1, 0);
        m0_req_i = 1'b0; m1_req_i = 1'b1; m1_addr_i = 10'd9; ret_req_i = 1'b1;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        ret_req_i = 1'b0;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        cycle(0, 1, 1, 0);
        m1_req_i = 1'b0;
        cycle(0, 0, 1, 0);

        // Reset right after a grant drops the response and restores priority.
        m0_req_i = 1'b1; m0_addr_i = 10'd3;
        cycle(1, 0, 1, 0);
        rst_i = 1'b1; m1_req_i = 1'b1;
        cycle(0, 0, 1, 0);
        rst_i = 1'b0;
        cycle(1, 0, 1, 0);
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        cycle(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
